// File: rtl/fifo_pkt_pkg.sv
// Shared types and constants for the length-prefixed packet reader.
package fifo_pkt_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int OUT_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_CHK = 2'd2
  } parse_state_t;

endpackage

// File: rtl/pkt_out_buf.sv
// Two-entry {data, sop, eop} buffer between the parser and the payload stream.
module pkt_out_buf
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_sop,
  input  logic                  push_eop,
  input  logic                  pop,
  output logic [1:0]            cnt,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_sop,
  output logic                  head_eop
);

  localparam logic [1:0] DEPTH = 2'(OUT_BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [OUT_BUF_DEPTH];
  logic                  mem_sop  [OUT_BUF_DEPTH];
  logic                  mem_eop  [OUT_BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt < DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_sop[i]  <= 1'b0;
        mem_eop[i]  <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= push_data;
        mem_sop[wr_ptr]  <= push_sop;
        mem_eop[wr_ptr]  <= push_eop;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Head fields are masked so the stream reads all-zero whenever nothing is queued.
  assign head_valid = (cnt != 2'd0);
  assign head_data  = head_valid ? mem_data[rd_ptr] : '0;
  assign head_sop   = head_valid & mem_sop[rd_ptr];
  assign head_eop   = head_valid & mem_eop[rd_ptr];

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a byte FIFO, parses LEN/payload/XOR-checksum frames and streams the payload.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  frame_done,
  output logic                  chk_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [1:0] DEPTH = 2'(OUT_BUF_DEPTH);

  parse_state_t          state, state_n;
  logic [DATA_WIDTH-1:0] remain, remain_n;
  logic [DATA_WIDTH-1:0] xor_acc, xor_n;
  logic                  sop_flag, sop_n;
  logic                  inflight;
  logic                  accept;
  logic [1:0]            buf_cnt;
  logic                  push, push_sop, push_eop;
  logic                  done_n, err_n;

  // Every outstanding read holds a buffer slot, so a returning payload byte always fits.
  assign rd_en  = reset & en & ((buf_cnt + {1'b0, inflight}) < DEPTH);
  assign accept = inflight & rd_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_HDR;
      remain     <= '0;
      xor_acc    <= '0;
      sop_flag   <= 1'b0;
      inflight   <= 1'b0;
      frame_done <= 1'b0;
      chk_err    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      remain     <= remain_n;
      xor_acc    <= xor_n;
      sop_flag   <= sop_n;
      inflight   <= rd_en;
      frame_done <= done_n;
      chk_err    <= err_n;
      frame_cnt  <= frame_cnt + CNT_WIDTH'(done_n);
      err_cnt    <= err_cnt + CNT_WIDTH'(err_n);
    end
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    xor_n    = xor_acc;
    sop_n    = sop_flag;
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (accept) begin
      case (state)
        S_HDR: begin
          if (rd_data == '0) begin
            err_n = 1'b1;
          end else begin
            remain_n = rd_data;
            xor_n    = '0;
            sop_n    = 1'b1;
            state_n  = S_PAY;
          end
        end
        S_PAY: begin
          push     = 1'b1;
          push_sop = sop_flag;
          push_eop = (remain == DATA_WIDTH'(1));
          xor_n    = xor_acc ^ rd_data;
          remain_n = remain - DATA_WIDTH'(1);
          sop_n    = 1'b0;
          if (remain == DATA_WIDTH'(1)) begin
            state_n = S_CHK;
          end
        end
        S_CHK: begin
          done_n  = 1'b1;
          err_n   = (rd_data != xor_acc);
          state_n = S_HDR;
        end
        default: state_n = S_HDR;
      endcase
    end
  end

  pkt_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rd_data),
    .push_sop  (push_sop),
    .push_eop  (push_eop),
    .pop       (out_valid & out_ready),
    .cnt       (buf_cnt),
    .head_valid(out_valid),
    .head_data (out_data),
    .head_sop  (out_sop),
    .head_eop  (out_eop)
  );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a byte-FIFO responder, a stream monitor and a vector table.
module tb_fifo_pkt_reader;
  import fifo_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_val;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        frame_done;
  logic        chk_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  typedef struct {
    string       name;
    int          n_in;
    logic [63:0] in_bytes;
    int          n_out;
    logic [63:0] out_bytes;
    logic [7:0]  sop_mask;
    logic [7:0]  eop_mask;
    int          frames;
    int          errs;
    logic        gaps;
  } vec_t;

  vec_t vecs [5];

  logic [7:0] model_q [$];
  logic [9:0] rx_q [$];
  logic       rd_req = 1'b0;
  logic       model_val = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic       late_val = 1'b0;
  logic       gap_mode = 1'b0;
  logic       gap_tog = 1'b0;
  int         served = 0;
  int         fd_pulses = 0;
  int         ce_pulses = 0;
  int         passed = 0;
  int         total = 0;
  int         exp_frames = 0;
  int         exp_errs = 0;

  assign rd_val  = model_val | late_val;
  assign rd_data = late_val ? 8'h03 : model_data;

  always #5 clk = ~clk;

  fifo_pkt_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_val    (rd_val),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .frame_done(frame_done),
    .chk_err   (chk_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  // Byte FIFO with one-cycle read latency; gap mode drops every other request.
  always @(negedge clk) rd_req <= rd_en;

  always @(posedge clk) begin
    if (rd_req && model_q.size() > 0 && !(gap_mode && gap_tog)) begin
      model_data <= model_q.pop_front();
      model_val  <= 1'b1;
      served++;
    end else begin
      model_val <= 1'b0;
    end
    if (rd_req) gap_tog <= ~gap_tog;
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) rx_q.push_back({out_data, out_sop, out_eop});
    if (frame_done) fd_pulses++;
    if (chk_err) ce_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic load_bytes(input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++) model_q.push_back(bytes[63-8*i -: 8]);
  endtask

  task automatic wait_drained(input string name, input int n_out);
    int cyc;
    cyc = 0;
    while (!(model_q.size() == 0 && rx_q.size() >= n_out) && cyc < 400) begin
      tick();
      cyc++;
    end
    check({name, "_timeout"}, (cyc < 400) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) tick();
  endtask

  task automatic apply_stimulus(input vec_t v, output int fd0, output int ce0, output int sv0);
    rx_q.delete();
    gap_mode = v.gaps;
    fd0 = fd_pulses;
    ce0 = ce_pulses;
    sv0 = served;
    load_bytes(v.n_in, v.in_bytes);
    wait_drained(v.name, v.n_out);
  endtask

  task automatic check_output(input vec_t v, input int fd0, input int ce0, input int sv0);
    logic [9:0] exp_rec;
    exp_frames += v.frames;
    exp_errs   += v.errs;
    @(negedge clk);
    check({v.name, "_rx_count"}, rx_q.size(), v.n_out);
    for (int i = 0; i < v.n_out && i < rx_q.size(); i++) begin
      exp_rec = {v.out_bytes[63-8*i -: 8], v.sop_mask[i], v.eop_mask[i]};
      check($sformatf("%s_byte%0d", v.name, i), {22'd0, rx_q[i]}, {22'd0, exp_rec});
    end
    check({v.name, "_frame_cnt"}, {16'd0, frame_cnt}, exp_frames);
    check({v.name, "_err_cnt"}, {16'd0, err_cnt}, exp_errs);
    check({v.name, "_done_pulses"}, fd_pulses - fd0, v.frames);
    check({v.name, "_err_pulses"}, ce_pulses - ce0, v.errs);
    check({v.name, "_reads"}, served - sv0, v.n_in);
    gap_mode = 1'b0;
  endtask

  initial begin
    int fd0, ce0, sv0, cyc;

    vecs[0] = '{"single", 5, 64'h03A1B2C3D0000000, 3, 64'hA1B2C30000000000, 8'b001, 8'b100, 1, 0, 1'b0};
    vecs[1] = '{"bad_chk", 4, 64'h0211220000000000, 2, 64'h1122000000000000, 8'b001, 8'b010, 1, 1, 1'b0};
    vecs[2] = '{"zero_len", 4, 64'h00015A5A00000000, 1, 64'h5A00000000000000, 8'b001, 8'b001, 1, 1, 1'b0};
    vecs[3] = '{"gaps", 5, 64'h03A1B2C3D0000000, 3, 64'hA1B2C30000000000, 8'b001, 8'b100, 1, 0, 1'b1};
    vecs[4] = '{"two_frames", 7, 64'h01FFFF020FF0FF00, 3, 64'hFF0FF00000000000, 8'b011, 8'b101, 2, 0, 1'b0};

    reset = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sop_eop", {out_sop, out_eop}, 0);
    check("rst_pulses", {frame_done, chk_err}, 0);
    check("rst_counters", {frame_cnt, err_cnt}, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i], fd0, ce0, sv0);
      check_output(vecs[i], fd0, ce0, sv0);
      if (i == 0) begin
        check("idle_rd_en", rd_en, 1);
        check("idle_rd_val", rd_val, 0);
      end
    end

    // Stall the stream: the buffer fills and reads stop with the head held.
    out_ready = 1'b0;
    rx_q.delete();
    fd0 = fd_pulses;
    load_bytes(6, 64'h0401020304040000);
    repeat (3) tick();
    @(negedge clk);
    check("bp_early_data", out_data, 8'h01);
    repeat (7) tick();
    @(negedge clk);
    check("bp_buf_cnt", dut.buf_cnt, 2);
    check("bp_rd_en", rd_en, 0);
    check("bp_head", {out_valid, out_sop, out_eop, out_data}, {3'b110, 8'h01});
    check("bp_pending", model_q.size(), 3);
    tick();
    out_ready = 1'b1;
    wait_drained("bp", 4);
    exp_frames++;
    @(negedge clk);
    check("bp_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      check($sformatf("bp_byte%0d", i), {22'd0, rx_q[i]},
            {22'd0, 8'(i + 1), (i == 0) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0});
    check("bp_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    check("bp_done_pulses", fd_pulses - fd0, 1);

    // Reset in the middle of a LEN=5 frame, then a late rd_val right after release.
    rx_q.delete();
    load_bytes(7, 64'h051020304050F000);
    cyc = 0;
    while (rx_q.size() < 2 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_reach_byte2", (cyc < 200) ? 32'd1 : 32'd0, 1);
    reset = 1'b0;
    tick();
    model_q.delete();
    tick();
    @(negedge clk);
    check("mid_rd_en", rd_en, 0);
    check("mid_out", {out_valid, out_sop, out_eop, out_data}, 0);
    check("mid_pulses", {frame_done, chk_err}, 0);
    check("mid_counters", {frame_cnt, err_cnt}, 0);
    check("mid_state", 32'(dut.state), 32'(S_HDR));
    check("mid_buf_cnt", dut.buf_cnt, 0);
    tick();
    reset = 1'b1;
    late_val = 1'b1;
    rx_q.delete();
    tick();
    late_val = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    apply_stimulus('{"post_rst", 4, 64'h02AA55FF00000000, 2, 64'hAA55000000000000,
                     8'b01, 8'b10, 1, 0, 1'b0}, fd0, ce0, sv0);
    check_output('{"post_rst", 4, 64'h02AA55FF00000000, 2, 64'hAA55000000000000,
                   8'b01, 8'b10, 1, 0, 1'b0}, fd0, ce0, sv0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
